elevator_car_controller: RTL and testbench
==========================================

# elevator_car_controller

Car motion controller that sits directly downstream of the elevator floor-decision state machine. It takes the 2-bit target floor that stage produces, drives the car one floor at a time with timed motor-up/motor-down commands, holds the door open for a fixed dwell, and reports the current floor. That current floor is fed back as the decision stage's present-floor input. Floors are 0–3, encoded 00/01/10/11.

## Interface
Parameters:
- FLOOR_CYCLES, default 8: clock cycles of motor drive per floor travelled; legal range 1–255.
- DOOR_CYCLES, default 4: clock cycles the door stays open on arrival; legal range 1–255.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  asynchronous, active-high reset.
- target_floor  input  2  requested floor from the decision stage.
- target_valid  input  1  request strobe; sampled only in IDLE.
- cur_floor  output  2  registered current floor; feeds the decision stage's present-floor input.
- motor_up  output  1  high while the car is moving up.
- motor_down  output  1  high while the car is moving down.
- door_open  output  1  high while the door is open.
- busy  output  1  high in any state other than IDLE.
- arrived  output  1  one-cycle pulse on the first cycle of DOOR.

## Operation
- The FSM has four states: IDLE, MOVE_UP, MOVE_DOWN, DOOR. Encoding is free.
- Internal registers:
  - tgt: latched target, 2 bits.
  - cnt: dwell/travel counter, 8 bits.
- IDLE:
  - If target_valid=1, latch tgt ← target_floor and clear cnt.
  - Next state is MOVE_UP if target_floor > cur_floor, MOVE_DOWN if target_floor < cur_floor, DOOR if they are equal.
  - If target_valid=0, stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - cnt increments each cycle.
  - When cnt == FLOOR_CYCLES-1: cur_floor ±1, cnt ← 0.
  - If the updated cur_floor == tgt, the next state is DOOR; otherwise stay in the same move state.
- DOOR:
  - cnt increments each cycle.
  - When cnt == DOOR_CYCLES-1: cnt ← 0, next state is IDLE.
- Outputs are decoded from the registered state (Moore):
  - motor_up = (state == MOVE_UP)
  - motor_down = (state == MOVE_DOWN)
  - door_open = (state == DOOR)
  - busy = (state != IDLE)
  - arrived = (state == DOOR) && (cnt == 0)
- motor_up and motor_down are never high together. door_open is never high with either motor signal.
- cur_floor cannot leave 0..3: the direction is chosen against a 2-bit tgt, so it cannot overshoot. No wrap logic is needed, and any 3→0 or 0→3 step is a bug.
- target_valid and target_floor are ignored outside IDLE. Changes in tgt mid-move are not possible.
- Reset (asynchronous, any time including mid-move or door open):
  - state ← IDLE
  - cur_floor ← 0
  - tgt ← 0
  - cnt ← 0
  - All outputs are 0 while reset is high and in the first cycle after release.

## Timing
- Request latency: target_valid is sampled at edge E. motor_up, motor_down, or door_open rises in the cycle after E.
- Travel: each floor takes exactly FLOOR_CYCLES cycles of motor assertion. For an N-floor trip, the motor is high for N×FLOOR_CYCLES consecutive cycles.
- cur_floor updates at the edge that ends each FLOOR_CYCLES block. On the final floor, that same edge moves the state into DOOR, so the motor falls and door_open rises in the same cycle.
- The door is high for exactly DOOR_CYCLES cycles. arrived is high for only the first of those cycles.
- busy then drops. A new request can be accepted in the first IDLE cycle, so there is a minimum 1-cycle IDLE gap between trips.
- Same-floor request: door_open is high for DOOR_CYCLES cycles starting one cycle after the accepting edge, with no motor activity and arrived pulsed.
- With FLOOR_CYCLES=1, cur_floor advances every cycle while moving.

## Test plan
- Reset: assert reset mid-cycle, asynchronously → all outputs 0 immediately. Release → cur_floor=0, busy=0.
- 0→3 trip with defaults:
  - target_floor=3, target_valid=1 for one cycle → motor_up high 24 cycles.
  - cur_floor reads 1, 2, 3 after cycles 8, 16, 24.
  - door_open high for 4 cycles, arrived high for 1 cycle, then busy=0.
- 3→1 trip: from floor 3, request 1 → motor_down high 16 cycles, cur_floor goes 2 then 1, door 4 cycles, motor_up never asserted.
- Same floor: at floor 2, request 2 → no motor activity, door_open high for 4 cycles, arrived pulses once, cur_floor stays 2.
- Ignored requests: during a 0→2 trip, pulse target_valid with target_floor=3 → trip still ends at floor 2 and the car returns to IDLE without moving to 3.
- Reset mid-move: reset asserted during the 0→3 trip at cur_floor=1 → immediate IDLE, cur_floor=0, motor_up=0. A subsequent request for 1 takes exactly 8 motor cycles.

Source files
------------

// File: rtl/elevator_car_controller.sv
// Car motion controller: walks the car one floor at a time toward a latched
// target, then holds the door for a fixed dwell before going idle again.
module elevator_car_controller #(
    parameter int unsigned FLOOR_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] target_floor,
    input  logic       target_valid,
    output logic [1:0] cur_floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic       busy,
    output logic       arrived
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DOOR
    } state_t;

    localparam logic [7:0] FLOOR_LAST = 8'(FLOOR_CYCLES - 1);
    localparam logic [7:0] DOOR_LAST  = 8'(DOOR_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] floor_q, floor_d;
    logic [1:0] tgt_q, tgt_d;
    logic [7:0] cnt_q, cnt_d;

    logic [1:0] floor_up;
    logic [1:0] floor_dn;
    logic       floor_done;
    logic       door_done;

    assign floor_up   = floor_q + 2'd1;
    assign floor_dn   = floor_q - 2'd1;
    assign floor_done = (cnt_q == FLOOR_LAST);
    assign door_done  = (cnt_q == DOOR_LAST);

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (target_valid) begin
                    tgt_d = target_floor;
                    cnt_d = 8'd0;
                    if (target_floor > floor_q) begin
                        state_d = S_UP;
                    end else if (target_floor < floor_q) begin
                        state_d = S_DOWN;
                    end else begin
                        state_d = S_DOOR;
                    end
                end
            end
            S_UP: begin
                if (floor_done) begin
                    cnt_d   = 8'd0;
                    floor_d = floor_up;
                    if (floor_up == tgt_q) begin
                        state_d = S_DOOR;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DOWN: begin
                if (floor_done) begin
                    cnt_d   = 8'd0;
                    floor_d = floor_dn;
                    if (floor_dn == tgt_q) begin
                        state_d = S_DOOR;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DOOR: begin
                if (door_done) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            floor_q <= 2'd0;
            tgt_q   <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decode straight off the registered state keeps the motor and
    // door signals mutually exclusive by construction.
    assign cur_floor  = floor_q;
    assign motor_up   = (state_q == S_UP);
    assign motor_down = (state_q == S_DOWN);
    assign door_open  = (state_q == S_DOOR);
    assign busy       = (state_q != S_IDLE);
    assign arrived    = (state_q == S_DOOR) && (cnt_q == 8'd0);

endmodule

// File: tb/tb_elevator_car_controller.sv
// Scoreboard bench: each request pushes the full expected per-cycle output
// trace; a negedge monitor pops and compares it against the car.
module tb_elevator_car_controller;

    localparam int FC = 8;
    localparam int DC = 4;

    typedef logic [6:0] vec_t;

    logic       clk;
    logic       reset;
    logic [1:0] target_floor;
    logic       target_valid;
    logic [1:0] cur_floor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic       busy;
    logic       arrived;

    int   n_cmp;
    int   n_bad;
    int   floor_m;
    vec_t q[$];

    elevator_car_controller #(
        .FLOOR_CYCLES(FC),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .target_floor(target_floor),
        .target_valid(target_valid),
        .cur_floor   (cur_floor),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .door_open   (door_open),
        .busy        (busy),
        .arrived     (arrived)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int f, bit up, bit dn, bit dr, bit arr);
        logic [1:0] fl;
        fl = 2'(f);
        return {fl, up, dn, dr, (up | dn | dr), arr};
    endfunction

    function automatic vec_t dut_vec();
        return {cur_floor, motor_up, motor_down, door_open, busy, arrived};
    endfunction

    task automatic chk(string nm, vec_t got, vec_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (floor,up,dn,door,busy,arr) t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && q.size() > 0) begin
            chk("trace", dut_vec(), q.pop_front());
        end
    end

    // Expected trace of a trip from f to t, straight from the travel rules.
    task automatic push_trip(int f, int t);
        int n;
        n = (t > f) ? t - f : f - t;
        for (int k = 0; k < n * FC; k++) begin
            if (t > f) q.push_back(mk(f + k / FC, 1, 0, 0, 0));
            else       q.push_back(mk(f - k / FC, 0, 1, 0, 0));
        end
        for (int i = 0; i < DC; i++) begin
            q.push_back(mk(t, 0, 0, 1, i == 0));
        end
    endtask

    // Requests arriving while the car is busy must be ignored.
    task automatic wait_drain();
        int budget;
        budget = 0;
        while (q.size() > 0) begin
            target_valid = 1'($urandom_range(0, 1));
            target_floor = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            budget++;
            if (budget > 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain_timeout: got %0d left expected 0", q.size());
                q.delete();
            end
        end
        target_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        wait_drain();
        target_valid = 1'b0;
        target_floor = 2'($urandom_range(0, 3));
        q.push_back(mk(floor_m, 0, 0, 0, 0));
        @(posedge clk);
        #1;
    endtask

    task automatic request(int t);
        wait_drain();
        target_valid = 1'b1;
        target_floor = 2'(t);
        q.push_back(mk(floor_m, 0, 0, 0, 0));
        push_trip(floor_m, t);
        floor_m = t;
        @(posedge clk);
        #1;
        target_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        floor_m      = 0;
        reset        = 1'b1;
        target_valid = 1'b0;
        target_floor = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held", dut_vec(), 7'd0);
        reset = 1'b0;
        q.push_back(mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;

        request(3);
        request(1);
        request(2);
        request(2);
        idle_cycle();
        request(0);
        request(2);
        request(0);

        // Asynchronous reset mid-trip, while the car is between floors 1 and 2.
        request(3);
        repeat (FC + 3) @(posedge clk);
        #3;
        chk("pre_reset", dut_vec(), mk(1, 1, 0, 0, 0));
        reset = 1'b1;
        #1;
        chk("async_reset", dut_vec(), 7'd0);
        q.delete();
        floor_m = 0;
        @(posedge clk);
        #1;
        chk("reset_hold2", dut_vec(), 7'd0);
        reset = 1'b0;
        q.push_back(mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        request(1);

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle();
            request($urandom_range(0, 3));
        end
        idle_cycle();
        idle_cycle();
        wait_drain();
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
